rr_arbiter16: RTL and testbench
===============================

# rr_arbiter16

Round-robin arbiter sharing one 16-way resource among 16 requesters. It registers a 4-bit winner index and drives the existing 4-to-16 `decoder` with that index, so the one-hot grant always matches the index exactly. Grants are held until the owner releases or an optional hold limit expires. The pointer then rotates past the released owner. The block sits between requester agents and the decoded select/enable lines of the shared resource.

## Interface
Parameters:
- MAX_HOLD, default 0: maximum grant length in cycles. 0 means no limit. Legal range is 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  16  request vector; bit i is requester i
- done  input  1  release strobe from the current owner; ignored when no grant is active
- gnt  output  16  one-hot grant; all zero when no grant is active
- gnt_id  output  4  index of the current owner; valid only while gnt_valid is high
- gnt_valid  output  1  a grant is active
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD

## Operation
- State register has three states: IDLE, GRANT, GAP. Other registers:
  - ptr[3:0]: priority pointer.
  - gnt_id[3:0]
  - hold_cnt[7:0]
- Reset values: state=IDLE, ptr=0, gnt_id=0, gnt_valid=0, gnt=0, timeout=0, hold_cnt=0.
- IDLE: if req≠0, the winner is the first set bit searching ptr, ptr+1, … ,15, 0, … ,ptr-1 (mod 16). On that edge:
  - gnt_id <= winner
  - gnt_valid <= 1
  - hold_cnt <= 1
  - state <= GRANT
- GRANT: the grant is released when any of the following holds:
  - done=1
  - req[gnt_id]=0
  - MAX_HOLD≠0 and hold_cnt==MAX_HOLD

  On release:
  - gnt_valid <= 0
  - ptr <= gnt_id+1, 4-bit wrap, so 15 → 0
  - state <= GAP

  Otherwise hold_cnt increments, saturating at 255.
- GAP lasts exactly one cycle with no grant, then state <= IDLE. New requests do not shorten the gap.
- timeout pulses 1 only if the release was caused solely by the hold limit. If done or request drop coincides with the limit, it is a normal release and timeout stays 0.
- gnt = decoder(ip=gnt_id, en=gnt_valid). No other logic drives gnt.
- Requests that change while a grant is held have no effect until the next IDLE arbitration. The owner is never pre-empted except by MAX_HOLD.

## Timing
- Grant latency: req sampled at edge N → gnt_valid/gnt high after edge N (1 cycle from first request).
- Release: done or drop of req[gnt_id] sampled at edge M → gnt low after M. gnt stays low through the GAP cycle. The next possible grant rises after edge M+2.
- Minimum request-to-request turnaround between different owners is 2 idle-free cycles plus the gap: grant, release edge, GAP, arbitration edge.
- Timeout: with MAX_HOLD=K, a grant taken at edge N is revoked at edge N+K. timeout is high for the cycle after edge N+K.
- rst_n asserted mid-grant clears all outputs immediately, without waiting for clk. Deassertion is synchronous to clk by the system reset synchroniser. The first arbitration occurs at the first edge after deassertion, with ptr=0.

## Structure
- Shared package holds:
  - state encoding constants: IDLE=2'd0, GRANT=2'd1, GAP=2'd2. 2'd3 is illegal and returns to IDLE.
  - N_REQ=16 and ID_W=4.
- One sub-module: instantiate the existing `decoder` (ip=gnt_id, op=gnt, en=gnt_valid).
- The round-robin search (priority rotate plus find-first) is a combinational function in the arbiter, not a separate module.

## Test plan
- Reset then req=16'h0001 → gnt_valid=1, gnt_id=0, gnt=16'h0001 one cycle later. done pulse → gnt=0 for 2 cycles, then re-granted to 0, with ptr=1 wrapping through.
- req=16'hFFFF held, done pulsed every grant → gnt_id sequence 0, 1, 2, …, 15, 0, with exactly one zero-grant cycle between each.
- ptr=15 (after granting 14), req=16'h8001 → grant 15. After release → grant 0, checking wrap.
- MAX_HOLD=4, req=16'h0004 held, no done → gnt high for 4 cycles, timeout pulses once, one gap cycle, re-grant to 2. Repeat with done on the limit cycle → timeout stays 0.
- Owner drops req[gnt_id] with no done → release identical to done. done asserted in IDLE with req=0 → no change.
- rst_n low mid-grant (gnt_id=9) → gnt, gnt_valid, timeout zero before the next clk edge. After release, req=16'h0200 → grant 9 via ptr=0 search.

Source files
------------

// File: rtl/rr_arbiter16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter: widths and FSM encoding.
package rr_arbiter16_pkg;

    localparam int unsigned N_REQ = 16;
    localparam int unsigned ID_W  = 4;
    localparam int unsigned CNT_W = 8;

    // 2'd3 is unused; the arbiter treats it as illegal and falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter16_decoder.sv
// 4-to-16 one-hot decoder with enable.
//   ip : binary index
//   en : output enable; op is all zero when low
//   op : one-hot decode of ip
module decoder
    import rr_arbiter16_pkg::*;
(
    input  logic [ID_W-1:0]  ip,
    input  logic             en,
    output logic [N_REQ-1:0] op
);

    // Single set bit at position ip when enabled.
    always_comb begin
        op = '0;
        if (en) begin
            op[ip] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for one resource shared by 16 requesters.
// A registered owner index drives the decoder, so the one-hot grant always
// matches gnt_id. Grants are held until the owner releases (done or request
// drop) or the optional MAX_HOLD limit expires, followed by a one-cycle gap.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector, bit i is requester i
//   done       : release strobe from the current owner
//   gnt        : one-hot grant (decoded from gnt_id/gnt_valid)
//   gnt_id     : owner index, valid while gnt_valid is high
//   gnt_valid  : a grant is active
//   timeout    : one-cycle pulse when the hold limit alone revoked a grant
module rr_arbiter16
    import rr_arbiter16_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [ID_W-1:0]    gnt_id_nxt;
    logic               gnt_valid_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic               timeout_nxt;
    logic               limit_hit;
    logic               owner_rel;

    // First set request searching from p upward, wrapping modulo 16.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  p);
        logic [ID_W-1:0] idx;
        logic            found;
        rr_pick = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = p + ID_W'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD));
    assign owner_rel = done || !req[gnt_id];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            hold_cnt  <= hold_cnt_nxt;
            timeout   <= timeout_nxt;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        hold_cnt_nxt  = hold_cnt;
        timeout_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_id_nxt    = rr_pick(req, ptr);
                    gnt_valid_nxt = 1'b1;
                    hold_cnt_nxt  = CNT_W'(1);
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                if (owner_rel || limit_hit) begin
                    gnt_valid_nxt = 1'b0;
                    ptr_nxt       = gnt_id + ID_W'(1);
                    state_nxt     = GAP;
                    // A coincident owner release makes this a normal release.
                    timeout_nxt   = limit_hit && !owner_rel;
                end else if (hold_cnt != '1) begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt     = IDLE;
                gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    // The grant lines come only from the decoded owner index.
    decoder u_decoder (
        .ip (gnt_id),
        .en (gnt_valid),
        .op (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16: one unlimited instance and one with MAX_HOLD=4,
// sharing inputs. Inputs change and outputs are sampled on the falling edge.
module tb_rr_arbiter16;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;

    logic [15:0] gnt0, gnt4;
    logic [3:0]  id0, id4;
    logic        v0, v4;
    logic        to0, to4;

    int n_checks;
    int n_pass;

    rr_arbiter16 dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt0),
        .gnt_id    (id0),
        .gnt_valid (v0),
        .timeout   (to0)
    );

    rr_arbiter16 #(.MAX_HOLD(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt4),
        .gnt_id    (id4),
        .gnt_valid (v4),
        .timeout   (to4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Pulse done across one edge and let the gap and idle cycles pass.
    task automatic release_and_wait();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("rel_gap1", 32'(v0), 32'd0);
        tick();
        check("rel_gap2", 32'(gnt0), 32'd0);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        req      = '0;
        done     = 1'b0;
        tick();
        tick();
        check("rst_gnt",   32'(gnt0), 32'd0);
        check("rst_valid", 32'(v0),   32'd0);
        check("rst_id",    32'(id0),  32'd0);
        check("rst_to",    32'(to4),  32'd0);
        rst_n = 1'b1;

        // Single requester, release by done, re-grant after wrap of ptr.
        req = 16'h0001;
        tick();
        check("t1_valid", 32'(v0),   32'd1);
        check("t1_id",    32'(id0),  32'd0);
        check("t1_gnt",   32'(gnt0), 32'h0001);
        release_and_wait();
        check("t1_regnt", 32'(gnt0), 32'h0001);
        req = '0;
        tick(); tick(); tick();

        // All requesting: strict rotation 0..15 then back to 0.
        do_reset();
        req = 16'hFFFF;
        tick();
        for (int k = 0; k <= 16; k++) begin
            check("t2_id",  32'(id0),  32'(k % 16));
            check("t2_gnt", 32'(gnt0), 32'd1 << (k % 16));
            if (k < 16) release_and_wait();
        end
        req = '0;
        tick(); tick(); tick();

        // ptr=15 after granting 14, then wrap from 15 to 0.
        do_reset();
        req = 16'h4000;
        tick();
        check("t3_id14", 32'(id0), 32'd14);
        req = 16'h8001;
        release_and_wait();
        check("t3_id15", 32'(id0), 32'd15);
        release_and_wait();
        check("t3_id0",  32'(id0), 32'd0);
        req = '0;
        tick(); tick(); tick();

        // Hold limit: 4 grant cycles, timeout pulse, gap, re-grant.
        do_reset();
        req = 16'h0004;
        tick();
        check("t4_v_c1", 32'(v4), 32'd1);
        tick();
        tick();
        tick();
        check("t4_v_c4",  32'(v4),  32'd1);
        check("t4_to_c4", 32'(to4), 32'd0);
        tick();
        check("t4_revoke", 32'(v4),  32'd0);
        check("t4_to",     32'(to4), 32'd1);
        check("t4_nolim",  32'(v0),  32'd1);
        check("t4_to0",    32'(to0), 32'd0);
        tick();
        check("t4_gap_v",  32'(v4),  32'd0);
        check("t4_to_end", 32'(to4), 32'd0);
        tick();
        check("t4_regnt", 32'(gnt4), 32'h0004);
        // done coincides with the limit: normal release, no timeout.
        tick(); tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t4b_v",  32'(v4),  32'd0);
        check("t4b_to", 32'(to4), 32'd0);
        req = '0;
        tick(); tick(); tick();

        // Request drop releases like done; done with no grant is ignored.
        do_reset();
        req = 16'h0020;
        tick();
        check("t5_id5", 32'(id0), 32'd5);
        req = '0;
        tick();
        check("t5_drop", 32'(gnt0), 32'd0);
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t5_idle_done", 32'(v0), 32'd0);
        req = 16'h0041;
        tick();
        check("t5_ptr6", 32'(id0), 32'd6);
        req = '0;
        tick(); tick(); tick();

        // Asynchronous reset mid-grant, then search restarts from ptr=0.
        do_reset();
        req = 16'h0200;
        tick();
        check("t6_id9", 32'(id0), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_gnt", 32'(gnt0), 32'd0);
        check("t6_rst_v",   32'(v0),   32'd0);
        check("t6_rst_to",  32'(to0),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_regnt_id",  32'(id0),  32'd9);
        check("t6_regnt_gnt", 32'(gnt0), 32'h0200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
